dma_tx_fwft_fifo: RTL and testbench
===================================

// Module: dma_tx_fwft_fifo
// PURPOSE
//  Parametrised first-word-fall-through FIFO for the DMA TX datapath, LANES parallel data lanes of DATA_W each.
//  Sits between the TX descriptor/data fetch stage and the PCIe TX packetiser; the head entry is always
//  presented on rd_data. Backing store is a 1-cycle-latency simple-dual-port RAM plus bypass/head registers.
//  Adds full/empty/level/almost-full status and sticky overflow/underflow error flags.
// PARAMETERS
//  DATA_W    512   width of one lane in bits
//  LANES     2     number of lanes written/read together (total width LANES*DATA_W)
//  DEPTH     2048  entries; power of two, >= 4
//  AFULL_TH  DEPTH-16  afull asserts when level >= AFULL_TH
//  AW        $clog2(DEPTH)  derived; pointer width
// PORTS
//  user_clk     in   1              clock
//  reset_n      in   1              asynchronous, active-low reset
//  push         in   1              write wr_data this cycle
//  wr_data      in   LANES*DATA_W   write data, lane i at [i*DATA_W +: DATA_W]
//  pop          in   1              consume current head
//  rd_data      out  LANES*DATA_W   head entry (valid while !empty)
//  empty        out  1              level == 0
//  full         out  1              level == DEPTH
//  afull        out  1              level >= AFULL_TH
//  level        out  AW+1           stored entry count
//  wr_ptr       out  AW             next RAM write address
//  rd_ptr       out  AW             address of current head
//  err_clr      in   1              synchronous clear of ovf_err/udf_err (and peak_level)
//  ovf_err      out  1              sticky: push while full without pop
//  udf_err      out  1              sticky: pop while empty
//  peak_level   out  AW+1           max level since reset/err_clr (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0 except empty=1; pointers, level, head/bypass regs 0. Reset mid-operation discards contents.
//  - Accepted push = push & (!full | pop). Accepted pop = pop & !empty. Rejected events change no pointer/level.
//  - wr_ptr/rd_ptr increment mod DEPTH on accepted push/pop; level +1, -1, or unchanged (both or neither).
//  - Invariant: every cycle with level >= 1, rd_data == oldest stored entry (entry at rd_ptr). Zero fall-through
//    latency: push at cycle t into empty FIFO -> at t+1 level=1, empty=0, rd_data=that word.
//  - Head refill after pop: next head sourced from (a) wr_data if it is being pushed this cycle and becomes head,
//    (b) 1-cycle-delayed write register if written last cycle (RAM not yet readable), else (c) RAM prefetch.
//    RAM read issued one cycle early at address rd_ptr+1 (prefetch after a write brings level to 2)
//    or rd_ptr+2 (accepted pop with level > 2).
//  - Back-to-back pop every cycle at full rate must be sustained with no bubble for any level.
//  - Empty: rd_data holds last value; pop ignored, udf_err<=1. Push+pop while empty: push accepted, pop rejected, udf_err<=1.
//  - Full: push+pop accepted (level stays DEPTH); push alone dropped, ovf_err<=1.
//  - err_clr has priority below a same-cycle error set (set wins).
//  - Pointer wrap DEPTH-1 -> 0 transparent; level never wraps.
// CONFIGURATION
//  DMA_TX_FIFO_PEAK_EN defined: peak_level register updates to level when level > peak_level; cleared by reset/err_clr.
//  Not defined: peak_level tied to 0, no register inferred.
// STRUCTURE
//  Package dma_tx_fifo_pkg: default DATA_W/LANES/DEPTH constants, typedef fifo_err_t {ovf, udf}.
//  Sub-module dma_tx_fifo_ram: SDP RAM, params W/DEPTH, ports clka/ena/wea/addra/dina, clkb/enb/addrb/doutb,
//  1-cycle read latency; instantiated once with width LANES*DATA_W.
// TESTING
//  1 Push 0xA1 into empty, no pop -> next cycle empty=0, level=1, rd_data=0xA1 (all lanes).
//  2 Push 5 words, then pop every cycle while pushing 1 new/cycle -> rd_data in exact order, no bubble, level stays 5.
//  3 Fill to DEPTH -> full=1, afull set at DEPTH-16; extra push -> ovf_err=1, level=DEPTH; push+pop -> level=DEPTH, order kept.
//  4 Pop on empty and push+pop on empty -> udf_err=1, second case level=1 with pushed word at head; err_clr -> flags 0.
//  5 Wrap: 3*DEPTH random push/pop traffic vs scoreboard model -> all data matches, wr_ptr/rd_ptr wrap to 0.
//  6 Assert reset_n mid-stream with level=7 -> level=0, empty=1, rd_data=0; with DMA_TX_FIFO_PEAK_EN peak_level=0 then tracks.

Source files
------------

// File: rtl/dma_tx_fifo_pkg.sv
// Package: dma_tx_fifo_pkg
// Shared constants and types for the DMA TX first-word-fall-through FIFO.
//   DEF_DATA_W / DEF_LANES / DEF_DEPTH : default geometry (512-bit lanes, 2 lanes, 2048 entries)
//   fifo_err_t                         : sticky error flag pair {ovf, udf}
package dma_tx_fifo_pkg;

  localparam int DEF_DATA_W = 512;
  localparam int DEF_LANES  = 2;
  localparam int DEF_DEPTH  = 2048;

  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_err_t;

endpackage

// File: rtl/dma_tx_fwft_fifo_if.sv
// Interface: dma_tx_fwft_fifo_if
// Push/pop handshake and head/status bundle of the DMA TX FWFT FIFO.
//   push, wr_data, pop      : driven by the master (fetch stage / packetiser side)
//   rd_data, empty, full,
//   afull                   : driven by the FIFO (slave)
// DW is the total data width (LANES*DATA_W) and must match the FIFO instance.
interface dma_tx_fwft_fifo_if
  import dma_tx_fifo_pkg::*;
#(
  parameter int DW = DEF_DATA_W * DEF_LANES
);

  logic          push;
  logic [DW-1:0] wr_data;
  logic          pop;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic          afull;

  modport master (output push, wr_data, pop, input rd_data, empty, full, afull);
  modport slave  (input push, wr_data, pop, output rd_data, empty, full, afull);

endinterface

// File: rtl/dma_tx_fifo_ram.sv
// Module: dma_tx_fifo_ram
// Simple dual-port RAM, one write port (a) and one read port (b), 1-cycle read
// latency. A read and a write to the same address in the same cycle return the
// old contents (read-first).
//   clka, ena, wea, addra, dina : write port
//   clkb, enb, addrb, doutb     : read port, doutb registered
module dma_tx_fifo_ram #(
  parameter  int W     = 1024,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clka,
  input  logic          ena,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [W-1:0]  dina,
  input  logic          clkb,
  input  logic          enb,
  input  logic [AW-1:0] addrb,
  output logic [W-1:0]  doutb
);

  // NOTE: the storage array has no reset so it maps onto block RAM; the FIFO
  // never presents an entry it has not written, so its power-up contents are
  // irrelevant.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clka) begin
    if (ena && wea) mem[addra] <= dina;
  end

  always_ff @(posedge clkb) begin
    if (enb) doutb <= mem[addrb];
  end

endmodule

// File: rtl/dma_tx_fwft_fifo.sv
// Module: dma_tx_fwft_fifo
// First-word-fall-through FIFO for the DMA TX datapath: LANES lanes of DATA_W
// bits move together. The head entry is held in a register and is always shown
// on rd_data; the body lives in a 1-cycle-latency SDP RAM.
// Ports:
//   user_clk, reset_n       : clock, asynchronous active-low reset
//   fifo (slave modport)    : push/wr_data/pop in, rd_data/empty/full/afull out
//   level                   : stored entry count (0..DEPTH)
//   wr_ptr / rd_ptr         : next write address / address of current head
//   err_clr                 : synchronous clear of ovf_err/udf_err/peak_level
//   ovf_err / udf_err       : sticky push-while-full / pop-while-empty flags
//   peak_level              : highest level seen since reset or err_clr
// Build option: define DMA_TX_FIFO_PEAK_EN to implement peak_level; otherwise
// it is tied to zero.
module dma_tx_fwft_fifo
  import dma_tx_fifo_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int LANES    = DEF_LANES,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int AFULL_TH = DEPTH - 16,
  localparam int AW       = $clog2(DEPTH),
  localparam int W        = LANES * DATA_W
) (
  input  logic              user_clk,
  input  logic              reset_n,
  dma_tx_fwft_fifo_if.slave fifo,
  output logic [AW:0]       level,
  output logic [AW-1:0]     wr_ptr,
  output logic [AW-1:0]     rd_ptr,
  input  logic              err_clr,
  output logic              ovf_err,
  output logic              udf_err,
  output logic [AW:0]       peak_level
);

  logic          push_acc, pop_acc, one_left;
  logic [AW:0]   level_nxt;
  logic [AW-1:0] rd_ptr_p1, rd_addr;
  logic [W-1:0]  head_q, head_nxt, ram_dout;
  // Copy of the last accepted write: that entry is not yet readable from RAM.
  logic          wr_q_vld;
  logic [AW-1:0] wr_q_addr;
  logic [W-1:0]  wr_q_data;
  fifo_err_t     err_q, err_set;

  assign fifo.empty = (level == '0);
  assign fifo.full  = (level == (AW+1)'(DEPTH));
  assign fifo.afull = (level >= (AW+1)'(AFULL_TH));
  assign one_left   = (level == (AW+1)'(1));

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_acc  = fifo.push & (~fifo.full | fifo.pop);
  assign pop_acc   = fifo.pop & ~fifo.empty;
  assign rd_ptr_p1 = rd_ptr + AW'(1);

  // Prefetch the entry that will follow the head in the next cycle, so a pop
  // then always finds its successor already on ram_dout.
  assign rd_addr = pop_acc ? rd_ptr + AW'(2) : rd_ptr_p1;

  // NOTE: combinational blocks assign every output a default first, so no
  // path can leave a value held and infer a latch.
  always_comb begin
    level_nxt = level;
    if (push_acc && !pop_acc)      level_nxt = level + (AW+1)'(1);
    else if (!push_acc && pop_acc) level_nxt = level - (AW+1)'(1);
  end

  // Head source: the incoming word when it becomes the head directly, else the
  // successor from the write copy (written last cycle) or from the prefetch.
  always_comb begin
    head_nxt = head_q;
    if (push_acc && (fifo.empty || (pop_acc && one_left)))
      head_nxt = fifo.wr_data;
    else if (pop_acc && !one_left)
      head_nxt = (wr_q_vld && (wr_q_addr == rd_ptr_p1)) ? wr_q_data : ram_dout;
  end

  // Set takes priority over a same-cycle clear.
  always_comb begin
    err_set.ovf = fifo.push & fifo.full & ~fifo.pop;
    err_set.udf = fifo.pop & fifo.empty;
  end

  dma_tx_fifo_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
    .clka  (user_clk),
    .ena   (push_acc),
    .wea   (1'b1),
    .addra (wr_ptr),
    .dina  (fifo.wr_data),
    .clkb  (user_clk),
    .enb   (level_nxt >= (AW+1)'(2)),
    .addrb (rd_addr),
    .doutb (ram_dout)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      head_q    <= '0;
      wr_q_vld  <= 1'b0;
      wr_q_addr <= '0;
      wr_q_data <= '0;
      err_q     <= '0;
    end else begin
      level    <= level_nxt;
      head_q   <= head_nxt;
      wr_q_vld <= push_acc;
      if (push_acc) begin
        wr_ptr    <= wr_ptr + AW'(1);
        wr_q_addr <= wr_ptr;
        wr_q_data <= fifo.wr_data;
      end
      if (pop_acc) rd_ptr <= rd_ptr_p1;
      err_q.ovf <= err_set.ovf | (err_q.ovf & ~err_clr);
      err_q.udf <= err_set.udf | (err_q.udf & ~err_clr);
    end
  end

  assign fifo.rd_data = head_q;
  assign ovf_err      = err_q.ovf;
  assign udf_err      = err_q.udf;

`ifdef DMA_TX_FIFO_PEAK_EN
  logic [AW:0] peak_q;

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n)           peak_q <= '0;
    else if (err_clr)       peak_q <= '0;
    else if (level > peak_q) peak_q <= level;
  end

  assign peak_level = peak_q;
`else
  assign peak_level = '0;
`endif

endmodule

// File: tb/tb_dma_tx_fwft_fifo.sv
// Testbench: tb_dma_tx_fwft_fifo
// Drives directed and randomized push/pop/err_clr traffic into a small
// dma_tx_fwft_fifo and compares every output each cycle against a queue-based
// reference model. Honors DMA_TX_FIFO_PEAK_EN the same way as the design.
module tb_dma_tx_fwft_fifo;

  localparam int DATA_W   = 16;
  localparam int LANES    = 2;
  localparam int DEPTH    = 32;
  localparam int AFULL_TH = DEPTH - 16;
  localparam int AW       = $clog2(DEPTH);
  localparam int W        = DATA_W * LANES;

  logic          user_clk = 1'b0;
  logic          reset_n  = 1'b0;
  logic          err_clr  = 1'b0;
  logic [AW:0]   level, peak_level;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          ovf_err, udf_err;

  dma_tx_fwft_fifo_if #(.DW(W)) fifo_if ();

  dma_tx_fwft_fifo #(
    .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)
  ) dut (
    .user_clk   (user_clk),
    .reset_n    (reset_n),
    .fifo       (fifo_if),
    .level      (level),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .err_clr    (err_clr),
    .ovf_err    (ovf_err),
    .udf_err    (udf_err),
    .peak_level (peak_level)
  );

  always #5 user_clk = ~user_clk;

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_head;
  int           m_wr, m_rd, m_peak;
  bit           m_ovf, m_udf;
  int           n_vec, n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head = '0;
    m_wr = 0; m_rd = 0; m_peak = 0;
    m_ovf = 0; m_udf = 0;
  endtask

  task automatic check_all();
    check("rd_data", 64'(fifo_if.rd_data), 64'(m_head));
    check("level",   64'(level),          64'(q.size()));
    check("empty",   64'(fifo_if.empty),  64'(q.size() == 0));
    check("full",    64'(fifo_if.full),   64'(q.size() == DEPTH));
    check("afull",   64'(fifo_if.afull),  64'(q.size() >= AFULL_TH));
    check("wr_ptr",  64'(wr_ptr),         64'(m_wr));
    check("rd_ptr",  64'(rd_ptr),         64'(m_rd));
    check("ovf_err", 64'(ovf_err),        64'(m_ovf));
    check("udf_err", 64'(udf_err),        64'(m_udf));
`ifdef DMA_TX_FIFO_PEAK_EN
    check("peak",    64'(peak_level),     64'(m_peak));
`else
    check("peak",    64'(peak_level),     64'(0));
`endif
  endtask

  // One clock: apply inputs, advance the model by the FIFO rules, compare after the edge.
  task automatic cycle(input bit p, input logic [W-1:0] d, input bit o, input bit clr);
    int lvl;
    bit pa, oa;
    fifo_if.push = p; fifo_if.wr_data = d; fifo_if.pop = o; err_clr = clr;
    lvl = q.size();
    oa  = o && (lvl != 0);
    pa  = p && ((lvl != DEPTH) || o);
    if (clr) m_peak = 0;
    else if (lvl > m_peak) m_peak = lvl;
    m_ovf = (p && (lvl == DEPTH) && !o) || (m_ovf && !clr);
    m_udf = (o && (lvl == 0)) || (m_udf && !clr);
    if (oa) begin q.delete(0); m_rd = (m_rd + 1) % DEPTH; end
    if (pa) begin q.push_back(d); m_wr = (m_wr + 1) % DEPTH; end
    if (q.size() > 0) m_head = q[0];
    @(posedge user_clk); #1;
    check_all();
  endtask

  function automatic logic [W-1:0] rnd_word();
    return W'($urandom);
  endfunction

  // Asynchronous reset in the middle of a cycle, checked while still asserted.
  task automatic mid_reset();
    fifo_if.push = 1'b0; fifo_if.pop = 1'b0; err_clr = 1'b0;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    #2 reset_n = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    fifo_if.push = 1'b0; fifo_if.pop = 1'b0; fifo_if.wr_data = '0;
    repeat (3) @(posedge user_clk);
    @(negedge user_clk) reset_n = 1'b1;
    @(posedge user_clk); #1;
    check_all();

    // 1: zero-latency fall-through into an empty FIFO
    cycle(1, {LANES{16'h00A1}}, 0, 0);
    cycle(0, '0, 0, 0);

    // 2: level 5, then pop+push every cycle; order and level preserved, no bubble
    for (int i = 0; i < 4; i++) cycle(1, rnd_word(), 0, 0);
    for (int i = 0; i < 12; i++) cycle(1, rnd_word(), 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);

    // 3: fill to DEPTH, overflow, push+pop at full, then drain at full rate
    for (int i = 0; i < DEPTH; i++) cycle(1, rnd_word(), 0, 0);
    cycle(1, rnd_word(), 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, rnd_word(), 1, 0);
    cycle(0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 0);

    // 4: underflow cases, set-beats-clear, clear
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 1);
    cycle(1, 32'hC0DE_0001, 1, 0);
    cycle(0, '0, 1, 1);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 1, 0);

    // 5: random traffic with fill/drain phases, several pointer wraps
    for (int i = 0; i < 6 * DEPTH; i++) begin
      bit fill_phase;
      fill_phase = ((i / DEPTH) % 2) == 0;
      cycle(($urandom_range(0, 99) < (fill_phase ? 80 : 35)),
            rnd_word(),
            ($urandom_range(0, 99) < (fill_phase ? 35 : 80)),
            ($urandom_range(0, 15) == 0));
    end

    // 6: reset with level 7, then peak tracks again from zero
    cycle(0, '0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1, 0);
    for (int i = 0; i < 7; i++) cycle(1, rnd_word(), 0, 0);
    mid_reset();
    for (int i = 0; i < 4; i++) cycle(1, rnd_word(), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
